// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: default sizing, op encoding and the
// operand bundle handed to the shared ALU.
package alu_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_TAG_DEPTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
    } alu_req_t;

endpackage

// File: rtl/alu_arb_tag_fifo.sv
// In-order FIFO of requester tags for operations in flight in the shared ALU.
module alu_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU among N_REQ requesters and
// routing each result back to its originator via an in-order tag FIFO.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_vld,
    output logic [N_REQ-1:0]      req_rdy,
    input  logic [N_REQ-1:0][7:0] req_a,
    input  logic [N_REQ-1:0][7:0] req_b,
    input  logic [N_REQ-1:0]      req_op,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [7:0]            rsp_q,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_op,
    output logic                  alu_in_vld,
    input  logic [7:0]            alu_q,
    input  logic                  alu_out_vld,
    output logic                  err_unexp
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [TAG_W-1:0] last_grant;
    logic [TAG_W-1:0] grant_idx;
    logic             grant;
    alu_req_t         sel_req;
    alu_req_t         alu_reg;

    logic [TAG_W-1:0] tag_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                 input logic [TAG_W-1:0] last);
        logic [N_REQ-1:0] pick;
        logic [TAG_W-1:0] idx;
        pick = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = TAG_W'((int'(last) + k) % N_REQ);
            if (vld[idx] && (pick == '0)) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_rdy   = '0;
        grant_idx = '0;
        // Gating on reset_n keeps req_rdy low for the whole reset, not just after it.
        if (reset_n && !fifo_full) req_rdy = rr_pick(req_vld, last_grant);
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rdy[i]) grant_idx = TAG_W'(i);
        end
        sel_req.a  = req_a[grant_idx];
        sel_req.b  = req_b[grant_idx];
        sel_req.op = req_op[grant_idx];
    end

    assign grant  = |req_rdy;
    assign alu_a  = alu_reg.a;
    assign alu_b  = alu_reg.b;
    assign alu_op = alu_reg.op;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= TAG_W'(N_REQ - 1);
            alu_reg    <= '0;
            alu_in_vld <= 1'b0;
            rsp_vld    <= '0;
            rsp_q      <= '0;
            err_unexp  <= 1'b0;
        end else begin
            alu_in_vld <= grant;
            if (grant) begin
                last_grant <= grant_idx;
                alu_reg    <= sel_req;
            end
            rsp_vld <= '0;
            if (alu_out_vld) begin
                if (!fifo_empty) begin
                    rsp_vld <= {{(N_REQ-1){1'b0}}, 1'b1} << tag_out;
                    rsp_q   <= alu_q;
                end else begin
                    err_unexp <= 1'b1;
                end
            end
        end
    end

    alu_arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (grant),
        .push_data (grant_idx),
        .pop       (alu_out_vld),
        .pop_data  (tag_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    count_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_count <= CNT_W'(TAG_DEPTH));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stub single-cycle ALU with stall and
// spurious-result injection, transaction-level reference model, random traffic.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_rdy;
    logic [N-1:0][7:0] req_a;
    logic [N-1:0][7:0] req_b;
    logic [N-1:0]     req_op;
    logic [N-1:0]     rsp_vld;
    logic [7:0]       rsp_q;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_op;
    logic             alu_in_vld;
    logic [7:0]       alu_q;
    logic             alu_out_vld;
    logic             err_unexp;

    alu_arbiter #(.N_REQ(N), .TAG_DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_vld     (rsp_vld),
        .rsp_q       (rsp_q),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_in_vld  (alu_in_vld),
        .alu_q       (alu_q),
        .alu_out_vld (alu_out_vld),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [7:0] res;
    } inflight_t;

    // Reference model: outstanding operations in issue order plus expected outputs.
    inflight_t  inflight[$];
    logic [7:0] stub_buf[$];
    int         last_g;
    int         model_grant;
    logic [N-1:0] exp_rsp_vld;
    logic [7:0] exp_rsp_q;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_op;
    logic       exp_in_vld;
    logic       exp_err;
    bit         stall;
    bit         spur;
    int         n_cmp;
    int         n_bad;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic op);
        int r;
        r = (op == OP_SUB) ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return 8'(r & 255);
    endfunction

    task automatic model_reset();
        inflight.delete();
        last_g      = N - 1;
        exp_rsp_vld = '0;
        exp_rsp_q   = '0;
        exp_a       = '0;
        exp_b       = '0;
        exp_op      = 1'b0;
        exp_in_vld  = 1'b0;
        exp_err     = 1'b0;
    endtask

    // One clock: check grant, advance model and stub ALU, check registered outputs.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int           g;
        logic         stub_in;
        logic [7:0]   stub_res;
        logic         nxt_vld;
        logic [7:0]   nxt_q;
        inflight_t    e;
        #1;
        exp_rdy = '0;
        g = -1;
        if (reset_n && inflight.size() < D) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last_g + k) % N;
                if (g < 0 && req_vld[i]) begin
                    g = i;
                    exp_rdy = N'(1) << i;
                end
            end
        end
        n_cmp++;
        if (req_rdy !== exp_rdy) begin
            n_bad++;
            $display("FAIL req_rdy: got %b expected %b at %0t", req_rdy, exp_rdy, $time);
        end
        stub_in  = alu_in_vld;
        stub_res = ref_alu(alu_a, alu_b, alu_op);
        model_grant = g;
        if (!reset_n) begin
            model_reset();
            stub_buf.delete();
        end else begin
            exp_rsp_vld = '0;
            if (alu_out_vld) begin
                if (inflight.size() > 0) begin
                    e = inflight.pop_front();
                    exp_rsp_vld = N'(1) << e.tag;
                    exp_rsp_q   = e.res;
                end else begin
                    exp_err = 1'b1;
                end
            end
            exp_in_vld = (g >= 0);
            if (g >= 0) begin
                inflight.push_back('{tag: g, res: ref_alu(req_a[g], req_b[g], req_op[g])});
                last_g = g;
                exp_a  = req_a[g];
                exp_b  = req_b[g];
                exp_op = req_op[g];
            end
            if (stub_in) stub_buf.push_back(stub_res);
        end
        nxt_vld = 1'b0;
        nxt_q   = alu_q;
        if (reset_n) begin
            if (spur) begin
                nxt_vld = 1'b1;
                nxt_q   = 8'($urandom);
            end else if (!stall && stub_buf.size() > 0) begin
                nxt_vld = 1'b1;
                nxt_q   = stub_buf.pop_front();
            end
        end
        spur = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_vld !== exp_rsp_vld) begin
            n_bad++;
            $display("FAIL rsp_vld: got %b expected %b at %0t", rsp_vld, exp_rsp_vld, $time);
        end
        n_cmp++;
        if (rsp_q !== exp_rsp_q) begin
            n_bad++;
            $display("FAIL rsp_q: got %h expected %h at %0t", rsp_q, exp_rsp_q, $time);
        end
        n_cmp++;
        if (alu_in_vld !== exp_in_vld) begin
            n_bad++;
            $display("FAIL alu_in_vld: got %b expected %b at %0t", alu_in_vld, exp_in_vld, $time);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== {exp_a, exp_b, exp_op}) begin
            n_bad++;
            $display("FAIL alu_operands: got %h/%h/%b expected %h/%h/%b at %0t",
                     alu_a, alu_b, alu_op, exp_a, exp_b, exp_op, $time);
        end
        n_cmp++;
        if (err_unexp !== exp_err) begin
            n_bad++;
            $display("FAIL err_unexp: got %b expected %b at %0t", err_unexp, exp_err, $time);
        end
        @(negedge clk);
        alu_out_vld = nxt_vld;
        alu_q       = nxt_q;
    endtask

    // New operands only for idle or just-granted requesters; waiting ones hold.
    task automatic drive_random(input int pct, input bit force_vld);
        for (int i = 0; i < N; i++) begin
            if (!req_vld[i] || model_grant == i) begin
                req_vld[i] = force_vld ? 1'b1 : ($urandom_range(0, 99) < pct);
                req_a[i]   = 8'($urandom);
                req_b[i]   = 8'($urandom);
                req_op[i]  = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_vld = '0;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_vld = '1;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        n_cmp++;
        if (req_rdy !== '0) begin
            n_bad++;
            $display("FAIL reset_rdy: got %b expected 0000", req_rdy);
        end
        req_vld = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_vld    = '0;
        req_vld[0] = 1'b1;
        req_a[0]   = 8'd5;
        req_b[0]   = 8'd3;
        req_op[0]  = OP_ADD;
        cycle();
        n_cmp++;
        if ({alu_in_vld, alu_a, alu_b, alu_op} !== {1'b1, 8'd5, 8'd3, OP_ADD}) begin
            n_bad++;
            $display("FAIL single_alu_in: got %b %h %h %b expected 1 05 03 0",
                     alu_in_vld, alu_a, alu_b, alu_op);
        end
        req_vld = '0;
        cycle();
        cycle();
        n_cmp++;
        if ({rsp_vld, rsp_q} !== {4'b0001, 8'd8}) begin
            n_bad++;
            $display("FAIL single_rsp: got %b %h expected 0001 08", rsp_vld, rsp_q);
        end
        cycle();
        n_cmp++;
        if ({rsp_vld, rsp_q} !== {4'b0000, 8'd8}) begin
            n_bad++;
            $display("FAIL single_strobe_hold: got %b %h expected 0000 08", rsp_vld, rsp_q);
        end
    endtask

    task automatic test_sub_wrap();
        req_vld    = 4'b0100;
        req_a[2]   = 8'd3;
        req_b[2]   = 8'd5;
        req_op[2]  = OP_SUB;
        cycle();
        req_vld = '0;
        cycle();
        cycle();
        n_cmp++;
        if ({rsp_vld, rsp_q} !== {4'b0100, 8'hFE}) begin
            n_bad++;
            $display("FAIL sub_wrap: got %b %h expected 0100 fe", rsp_vld, rsp_q);
        end
        req_vld    = 4'b0100;
        req_a[2]   = 8'hFF;
        req_b[2]   = 8'h01;
        req_op[2]  = OP_ADD;
        cycle();
        req_vld = '0;
        cycle();
        cycle();
        n_cmp++;
        if ({rsp_vld, rsp_q} !== {4'b0100, 8'h00}) begin
            n_bad++;
            $display("FAIL add_wrap: got %b %h expected 0100 00", rsp_vld, rsp_q);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rsp;
        do_reset();
        model_grant = -1;
        req_vld = '0;
        drive_random(100, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                #1;
                n_cmp++;
                if (req_rdy !== (N'(1) << (c % N))) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: got %b expected %b", c, req_rdy, N'(1) << (c % N));
                end
            end
            cycle();
            exp_rsp = (c >= 2 && c < 10) ? (N'(1) << ((c - 2) % N)) : '0;
            n_cmp++;
            if (rsp_vld !== exp_rsp) begin
                n_bad++;
                $display("FAIL rr_rsp%0d: got %b expected %b", c, rsp_vld, exp_rsp);
            end
            if (c < 7) drive_random(100, 1'b1);
            else req_vld = '0;
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        stall = 1'b1;
        model_grant = -1;
        req_vld = '0;
        drive_random(100, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle();
            drive_random(100, 1'b1);
        end
        #1;
        n_cmp++;
        if (req_rdy !== '0) begin
            n_bad++;
            $display("FAIL full_rdy: got %b expected 0000", req_rdy);
        end
        stall = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            drive_random(100, 1'b1);
        end
        req_vld = '0;
        for (int c = 0; c < 8; c++) cycle();
    endtask

    task automatic test_spurious();
        do_reset();
        cycle();
        spur = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({err_unexp, rsp_vld} !== {1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL spurious: got err=%b rsp=%b expected err=1 rsp=0000", err_unexp, rsp_vld);
        end
        for (int c = 0; c < 3; c++) cycle();
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b expected 1", err_unexp);
        end
        do_reset();
        n_cmp++;
        if (err_unexp !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b expected 0", err_unexp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_vld   = 4'b0011;
        req_a[0]  = 8'd10;
        req_b[0]  = 8'd20;
        req_op[0] = OP_ADD;
        req_a[1]  = 8'd30;
        req_b[1]  = 8'd7;
        req_op[1] = OP_SUB;
        cycle();
        req_vld[0] = 1'b0;
        cycle();
        req_vld = '0;
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if (rsp_vld !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_rsp%0d: got %b expected 0000", c, rsp_vld);
            end
        end
        req_vld = '1;
        #1;
        n_cmp++;
        if (req_rdy !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_mid_grant: got %b expected 0001", req_rdy);
        end
        cycle();
        req_vld = '0;
        for (int c = 0; c < 4; c++) cycle();
    endtask

    task automatic test_random();
        do_reset();
        model_grant = -1;
        req_vld = '0;
        drive_random(60, 1'b0);
        for (int c = 0; c < 400; c++) begin
            cycle();
            if ($urandom_range(0, 9) == 0) stall = !stall;
            drive_random(60, 1'b0);
        end
        stall   = 1'b0;
        req_vld = '0;
        for (int c = 0; c < 10; c++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        stall       = 1'b0;
        spur        = 1'b0;
        model_grant = -1;
        reset_n     = 1'b0;
        req_vld     = '0;
        req_a       = '0;
        req_b       = '0;
        req_op      = '0;
        alu_q       = '0;
        alu_out_vld = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_sub_wrap();
        test_round_robin();
        test_fifo_full();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
